// File: rtl/dcache_pkg.sv
// Shared constants, size codes, FSM state type and lane helpers for the
// direct-mapped write-through data cache controller.
package dcache_pkg;

   localparam int unsigned ADDR_W    = 12;
   localparam int unsigned TAG_W     = 3;
   localparam int unsigned INDEX_W   = 5;
   localparam int unsigned OFFS_W    = 4;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned LINE_W    = 128;
   localparam int unsigned NUM_LINES = 32;

   localparam int unsigned TAG_LSB   = INDEX_W + OFFS_W;
   localparam int unsigned INDEX_LSB = OFFS_W;
   localparam int unsigned WORD_LSB  = 2;

   localparam logic [1:0] SZ_NONE = 2'd0;
   localparam logic [1:0] SZ_BYTE = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;
   localparam logic [1:0] SZ_WORD = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REFILL,
      S_WRITE,
      S_DONE
   } state_t;

   // Byte lane where an access of the given size starts; halves ignore addr[0],
   // words ignore addr[1:0].
   function automatic logic [1:0] lane_offs(input logic [1:0] sz, input logic [1:0] offs);
      case (sz)
         SZ_BYTE: return offs;
         SZ_HALF: return {offs[1], 1'b0};
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] offs);
      case (sz)
         SZ_BYTE: return 4'b0001 << offs;
         SZ_HALF: return 4'b0011 << {offs[1], 1'b0};
         SZ_WORD: return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read port, synchronous write port,
// valid bits cleared asynchronously on reset.
module dcache_array
   import dcache_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [INDEX_W-1:0]   rd_index,
   output logic                 rd_valid,
   output logic [TAG_W-1:0]     rd_tag,
   output logic [LINE_W-1:0]    rd_line,
   input  logic                 wr_en,
   input  logic [INDEX_W-1:0]   wr_index,
   input  logic [TAG_W-1:0]     wr_tag,
   input  logic [LINE_W-1:0]    wr_line
);

   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tags  [NUM_LINES];
   logic [LINE_W-1:0]    lines [NUM_LINES];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         valid <= '0;
      else if (wr_en)
         valid[wr_index] <= 1'b1;
   end

   // Tag and data need no reset; an invalid line never hits.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_index]  <= wr_tag;
         lines[wr_index] <= wr_line;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_line  = lines[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller between
// the single-cycle core and a multi-cycle line-based main memory.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   Data_addr,
   input  logic [1:0]          we,
   input  logic [1:0]          re,
   input  logic [WORD_W-1:0]   Wdata,
   output logic [WORD_W-1:0]   Rdata,
   output logic                Stall,
   output logic                mem_rd_req,
   output logic                mem_wr_req,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [WORD_W-1:0]   mem_wdata,
   output logic [3:0]          mem_wmask,
   input  logic [LINE_W-1:0]   mem_rdata,
   input  logic                mem_ready,
   output logic [CNT_W-1:0]    hit_cnt,
   output logic [CNT_W-1:0]    miss_cnt
);

   state_t              state;
   logic                refilled;

   logic [INDEX_W-1:0]  rd_index;
   logic                arr_valid;
   logic [TAG_W-1:0]    arr_tag;
   logic [LINE_W-1:0]   arr_line;

   logic                wr_en;
   logic [LINE_W-1:0]   wr_line;
   logic [LINE_W-1:0]   merged;

   logic                hit;
   logic                wr_hit;
   logic [WORD_W-1:0]   rd_word;
   logic [1:0]          st_offs;
   logic [3:0]          st_mask;
   logic [WORD_W-1:0]   st_data;
   logic [6:0]          wsel_base;

   // While a write-through is pending the array is looked up with the latched
   // store address so the merge targets the right line.
   assign rd_index = (state == S_WRITE) ? mem_addr[TAG_LSB-1:INDEX_LSB]
                                        : Data_addr[TAG_LSB-1:INDEX_LSB];

   dcache_array u_array (
      .clk      (clk),
      .reset    (reset),
      .rd_index (rd_index),
      .rd_valid (arr_valid),
      .rd_tag   (arr_tag),
      .rd_line  (arr_line),
      .wr_en    (wr_en),
      .wr_index (mem_addr[TAG_LSB-1:INDEX_LSB]),
      .wr_tag   (mem_addr[ADDR_W-1:TAG_LSB]),
      .wr_line  (wr_line)
   );

   function automatic logic [WORD_W-1:0] load_lane(input logic [1:0] sz,
                                                   input logic [1:0] offs,
                                                   input logic [WORD_W-1:0] word);
      case (sz)
         SZ_BYTE: return {24'd0, word[{offs, 3'b000} +: 8]};
         SZ_HALF: return {16'd0, word[{offs[1], 4'b0000} +: 16]};
         SZ_WORD: return word;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      rd_word = arr_line[{Data_addr[WORD_LSB+1:WORD_LSB], 5'd0} +: WORD_W];
      hit     = arr_valid && (arr_tag == Data_addr[ADDR_W-1:TAG_LSB]);
      Stall   = 1'b0;
      Rdata   = '0;
      case (state)
         S_IDLE: begin
            if (we != SZ_NONE)
               Stall = 1'b1;
            else if (re != SZ_NONE) begin
               if (hit)
                  Rdata = load_lane(re, Data_addr[1:0], rd_word);
               else
                  Stall = 1'b1;
            end
         end
         S_REFILL, S_WRITE: Stall = 1'b1;
         default: Stall = 1'b0;
      endcase
   end

   always_comb begin
      st_offs = lane_offs(we, Data_addr[1:0]);
      st_mask = byte_mask(we, Data_addr[1:0]);
      st_data = '0;
      for (int unsigned b = 0; b < 4; b++)
         if (st_mask[b])
            st_data[b*8 +: 8] = Wdata[(b - 32'(st_offs))*8 +: 8];
   end

   always_comb begin
      wsel_base = {mem_addr[WORD_LSB+1:WORD_LSB], 5'd0};
      wr_hit    = arr_valid && (arr_tag == mem_addr[ADDR_W-1:TAG_LSB]);
      merged    = arr_line;
      for (int unsigned b = 0; b < 4; b++)
         if (mem_wmask[b])
            merged[wsel_base + 7'(b*8) +: 8] = mem_wdata[b*8 +: 8];
      wr_en   = 1'b0;
      wr_line = merged;
      if (state == S_REFILL && mem_ready) begin
         wr_en   = 1'b1;
         wr_line = mem_rdata;
      end else if (state == S_WRITE && mem_ready && wr_hit) begin
         wr_en   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         refilled   <= 1'b0;
         mem_rd_req <= 1'b0;
         mem_wr_req <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wmask  <= '0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
      end else begin
         refilled <= 1'b0;
         case (state)
            S_IDLE: begin
               if (we != SZ_NONE) begin
                  mem_wr_req <= 1'b1;
                  mem_addr   <= {Data_addr[ADDR_W-1:WORD_LSB], 2'b00};
                  mem_wdata  <= st_data;
                  mem_wmask  <= st_mask;
                  state      <= S_WRITE;
               end else if (re != SZ_NONE) begin
                  if (hit) begin
                     // The re-presented load after a fill is not a new hit.
                     if (!refilled && hit_cnt != '1)
                        hit_cnt <= hit_cnt + CNT_W'(1);
                  end else begin
                     if (miss_cnt != '1)
                        miss_cnt <= miss_cnt + CNT_W'(1);
                     mem_rd_req <= 1'b1;
                     mem_addr   <= {Data_addr[ADDR_W-1:INDEX_LSB], 4'b0000};
                     state      <= S_REFILL;
                  end
               end
            end
            S_REFILL: begin
               if (mem_ready) begin
                  mem_rd_req <= 1'b0;
                  refilled   <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            S_WRITE: begin
               if (mem_ready) begin
                  mem_wr_req <= 1'b0;
                  state      <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
